nios_noc_bridge: RTL and testbench

Bridge between the Nios II PIO message ports and the TDMA network-on-chip. It turns level-type PIO writes (send address/data) into one-shot network transmit packets through a TX FIFO. It buffers incoming network packets in an RX FIFO and presents them one at a time on the receive PIOs, using a toggle/acknowledge protocol software can poll. It sits directly between the Nios system and the NoC port of the processing node.

---
 rtl/nios_noc_pkg.sv | 20 ++
 rtl/nios_noc_bridge_sync_fifo.sv | 51 +++++
 rtl/nios_noc_bridge.sv | 154 +++++++++++++++
 tb/tb_nios_noc_bridge.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_noc_pkg.sv
// Shared NoC packet definitions for the Nios II PIO to TDMA NoC bridge.
package nios_noc_pkg;

  localparam int NOC_ADDR_W = 7;
  localparam int NOC_DATA_W = 31;
  localparam int NOC_PKT_W  = NOC_ADDR_W + NOC_DATA_W;

  // One network packet: destination/source port plus payload (38 bits).
  typedef struct packed {
    logic [NOC_ADDR_W-1:0] addr;
    logic [NOC_DATA_W-1:0] data;
  } noc_pkt_t;

  // Presentation register occupancy.
  typedef enum logic [0:0] {
    PR_EMPTY = 1'b0,
    PR_HELD  = 1'b1
  } pr_state_t;

endpackage

// File: rtl/nios_noc_bridge_sync_fifo.sv
// Synchronous FIFO with registered pointers. The extra pointer MSB tells
// full from empty. A push into a full FIFO succeeds only with a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop; wrap is implicit in the pointer width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is cleared on reset so the head fields read as zero afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/nios_noc_bridge.sv
// Bridge between Nios II PIO message ports and the TDMA NoC port. Toggle
// edges on the send PIOs become one-shot TX packets; received packets are
// shown one at a time on the receive PIOs with a toggle/ack handshake.
module nios_noc_bridge
  import nios_noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            pio_send_addr,
  input  logic [31:0]           pio_send_data,
  output logic [7:0]            pio_recv_addr,
  output logic [31:0]           pio_recv_data,
  output logic                  noc_tx_valid,
  input  logic                  noc_tx_ready,
  output logic [NOC_ADDR_W-1:0] noc_tx_addr,
  output logic [NOC_DATA_W-1:0] noc_tx_data,
  input  logic                  noc_rx_valid,
  input  logic [NOC_ADDR_W-1:0] noc_rx_addr,
  input  logic [NOC_DATA_W-1:0] noc_rx_data,
  output logic                  tx_full,
  output logic [DROP_W-1:0]     tx_drop_cnt,
  output logic [DROP_W-1:0]     rx_drop_cnt
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + {{(DROP_W-1){1'b0}}, 1'b1};
  endfunction

  logic              primed;
  logic              tx_tog;
  logic              ack;
  logic              tx_req;
  logic              ack_evt;
  logic              tx_pop;
  logic              tx_empty;
  logic              tx_drop;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_drop;
  logic              pr_load;
  noc_pkt_t          tx_in;
  noc_pkt_t          tx_head;
  noc_pkt_t          rx_in;
  noc_pkt_t          rx_head;
  pr_state_t         pr_state;
  pr_state_t         pr_next;
  logic [6:0]        recv_addr;
  logic [31:0]       recv_data;

  // Toggle edges only count once the first post-reset edge has sampled the
  // software's current toggle levels.
  assign tx_req  = primed & (pio_send_data[31] ^ tx_tog);
  assign ack_evt = primed & (pio_send_addr[7] ^ ack);
  assign tx_pop  = ~tx_empty & noc_tx_ready;
  assign tx_drop = tx_req & tx_full & ~tx_pop;
  assign rx_drop = noc_rx_valid & rx_full & ~pr_load;

  assign tx_in   = '{addr: pio_send_addr[6:0], data: pio_send_data[30:0]};
  assign rx_in   = '{addr: noc_rx_addr, data: noc_rx_data};

  assign noc_tx_valid  = ~tx_empty;
  assign noc_tx_addr   = tx_head.addr;
  assign noc_tx_data   = tx_head.data;
  assign pio_recv_addr = {1'b0, recv_addr};
  assign pio_recv_data = recv_data;

  sync_fifo #(.WIDTH(NOC_PKT_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_req),
    .pop     (tx_pop),
    .wdata   (tx_in),
    .rdata   (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  sync_fifo #(.WIDTH(NOC_PKT_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (noc_rx_valid),
    .pop     (pr_load),
    .wdata   (rx_in),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // Priming flag and last-seen software toggle levels (tracked every cycle).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed <= 1'b0;
      tx_tog <= 1'b0;
      ack    <= 1'b0;
    end else begin
      primed <= 1'b1;
      tx_tog <= pio_send_data[31];
      ack    <= pio_send_addr[7];
    end
  end

  // Presentation register state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pr_state <= PR_EMPTY;
    else          pr_state <= pr_next;
  end

  // Presentation register next state: fill from RX FIFO, release on ack.
  always_comb begin
    pr_next = pr_state;
    case (pr_state)
      PR_EMPTY: if (!rx_empty) pr_next = PR_HELD;  else pr_next = PR_EMPTY;
      PR_HELD:  if (ack_evt)   pr_next = PR_EMPTY; else pr_next = PR_HELD;
      default:  pr_next = PR_EMPTY;
    endcase
  end

  // Presentation register outputs: load (and pop) the RX head when empty.
  always_comb begin
    pr_load = 1'b0;
    case (pr_state)
      PR_EMPTY: pr_load = ~rx_empty;
      PR_HELD:  pr_load = 1'b0;
      default:  pr_load = 1'b0;
    endcase
  end

  // Receive PIO registers; bit 31 flips on each newly presented word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      recv_addr <= 7'd0;
      recv_data <= 32'd0;
    end else if (pr_load) begin
      recv_addr <= rx_head.addr;
      recv_data <= {~recv_data[31], rx_head.data};
    end
  end

  // Saturating drop counters for requests/packets lost on a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_drop_cnt <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (tx_drop) tx_drop_cnt <= sat_inc(tx_drop_cnt);
      if (rx_drop) rx_drop_cnt <= sat_inc(rx_drop_cnt);
    end
  end

endmodule

// File: tb/tb_nios_noc_bridge.sv
// Self-checking bench for nios_noc_bridge: a TX vector table, hand-written
// RX / reset sequences, and random traffic against a queue-based model.
module tb_nios_noc_bridge;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  pio_send_addr;
  logic [31:0] pio_send_data;
  logic [7:0]  pio_recv_addr;
  logic [31:0] pio_recv_data;
  logic        noc_tx_valid;
  logic        noc_tx_ready;
  logic [6:0]  noc_tx_addr;
  logic [30:0] noc_tx_data;
  logic        noc_rx_valid;
  logic [6:0]  noc_rx_addr;
  logic [30:0] noc_rx_data;
  logic        tx_full;
  logic [DW-1:0] tx_drop_cnt;
  logic [DW-1:0] rx_drop_cnt;

  always #5 clk = ~clk;

  nios_noc_bridge #(.FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .pio_send_addr(pio_send_addr), .pio_send_data(pio_send_data),
    .pio_recv_addr(pio_recv_addr), .pio_recv_data(pio_recv_data),
    .noc_tx_valid(noc_tx_valid), .noc_tx_ready(noc_tx_ready),
    .noc_tx_addr(noc_tx_addr), .noc_tx_data(noc_tx_data),
    .noc_rx_valid(noc_rx_valid), .noc_rx_addr(noc_rx_addr), .noc_rx_data(noc_rx_data),
    .tx_full(tx_full), .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic [6:0] a; logic [30:0] d; } pkt_t;
  pkt_t        m_txq[$];
  pkt_t        m_rxq[$];
  bit          m_primed, m_tog, m_ack, m_held;
  logic [6:0]  m_raddr;
  logic [31:0] m_rdata;
  int          m_txdrop, m_rxdrop;

  task automatic model_reset();
    m_txq.delete(); m_rxq.delete();
    m_primed = 0; m_tog = 0; m_ack = 0; m_held = 0;
    m_raddr = 7'd0; m_rdata = 32'd0; m_txdrop = 0; m_rxdrop = 0;
  endtask

  // What one clock edge does, given the inputs currently driven.
  task automatic model_edge();
    bit   tx_req, ack_evt, was_tx_full, was_rx_full, tx_pop, rx_pop;
    pkt_t p;
    tx_req      = m_primed && (pio_send_data[31] != m_tog);
    ack_evt     = m_primed && (pio_send_addr[7] != m_ack);
    was_tx_full = (m_txq.size() == DEPTH);
    was_rx_full = (m_rxq.size() == DEPTH);
    tx_pop      = (m_txq.size() > 0) && noc_tx_ready;
    rx_pop      = !m_held && (m_rxq.size() > 0);
    if (tx_pop) p = m_txq.pop_front();
    if (tx_req) begin
      if (!was_tx_full || tx_pop) begin
        p.a = pio_send_addr[6:0]; p.d = pio_send_data[30:0]; m_txq.push_back(p);
      end else m_txdrop++;
    end
    if (rx_pop) begin
      p = m_rxq.pop_front();
      m_raddr = p.a;
      m_rdata = {~m_rdata[31], p.d};
    end
    if (noc_rx_valid) begin
      if (!was_rx_full || rx_pop) begin
        p.a = noc_rx_addr; p.d = noc_rx_data; m_rxq.push_back(p);
      end else m_rxdrop++;
    end
    if (rx_pop) m_held = 1;
    else if (m_held && ack_evt) m_held = 0;
    m_primed = 1; m_tog = pio_send_data[31]; m_ack = pio_send_addr[7];
  endtask

  task automatic model_compare();
    int sat_tx, sat_rx;
    sat_tx = (m_txdrop > 255) ? 255 : m_txdrop;
    sat_rx = (m_rxdrop > 255) ? 255 : m_rxdrop;
    chk("m_tx_valid", {31'd0, noc_tx_valid}, {31'd0, m_txq.size() > 0});
    chk("m_tx_full",  {31'd0, tx_full}, {31'd0, m_txq.size() == DEPTH});
    if (m_txq.size() > 0) begin
      chk("m_tx_addr", {25'd0, noc_tx_addr}, {25'd0, m_txq[0].a});
      chk("m_tx_data", {1'b0, noc_tx_data}, {1'b0, m_txq[0].d});
    end
    chk("m_tx_drop",   {24'd0, tx_drop_cnt}, sat_tx);
    chk("m_rx_drop",   {24'd0, rx_drop_cnt}, sat_rx);
    chk("m_recv_addr", {24'd0, pio_recv_addr}, {25'd0, m_raddr});
    chk("m_recv_data", pio_recv_data, m_rdata);
  endtask

  // One clock: inputs are already driven; sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_compare();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_recv_addr"}, {24'd0, pio_recv_addr}, 32'd0);
    chk({tag, "_recv_data"}, pio_recv_data, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, noc_tx_valid}, 32'd0);
    chk({tag, "_tx_addr"}, {25'd0, noc_tx_addr}, 32'd0);
    chk({tag, "_tx_data"}, {1'b0, noc_tx_data}, 32'd0);
    chk({tag, "_tx_full"}, {31'd0, tx_full}, 32'd0);
    chk({tag, "_tx_drop"}, {24'd0, tx_drop_cnt}, 32'd0);
    chk({tag, "_rx_drop"}, {24'd0, rx_drop_cnt}, 32'd0);
  endtask

  task automatic do_reset(input logic [7:0] a, input logic [31:0] d);
    reset_n = 1'b0;
    pio_send_addr = a; pio_send_data = d;
    noc_tx_ready = 1'b0; noc_rx_valid = 1'b0; noc_rx_addr = 7'd0; noc_rx_data = 31'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rx_pkt(input logic v, input logic [6:0] a, input logic [30:0] d);
    noc_rx_valid = v; noc_rx_addr = a; noc_rx_data = d;
  endtask

  // ---------------- TX vector table ----------------
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic        rdy;
    logic        e_valid;
    logic        e_full;
    logic [6:0]  e_addr;
    logic [30:0] e_data;
    logic [7:0]  e_drop;
  } tvec_t;
  tvec_t tv[13];

  logic ack_bit;

  initial begin
    tv[0]  = '{8'h05, 32'h8000_1234, 1'b0, 1'b0, 1'b0, 7'h00, 31'h0,    8'd0};
    tv[1]  = '{8'h05, 32'h8000_1234, 1'b0, 1'b0, 1'b0, 7'h00, 31'h0,    8'd0};
    tv[2]  = '{8'h05, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 7'h05, 31'h1234, 8'd0};
    tv[3]  = '{8'h05, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 7'h05, 31'h1234, 8'd0};
    tv[4]  = '{8'h06, 32'h8000_0011, 1'b0, 1'b1, 1'b0, 7'h05, 31'h1234, 8'd0};
    tv[5]  = '{8'h07, 32'h0000_0022, 1'b0, 1'b1, 1'b0, 7'h05, 31'h1234, 8'd0};
    tv[6]  = '{8'h08, 32'h8000_0033, 1'b0, 1'b1, 1'b1, 7'h05, 31'h1234, 8'd0};
    tv[7]  = '{8'h09, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 7'h05, 31'h1234, 8'd1};
    tv[8]  = '{8'h0a, 32'h8000_0055, 1'b0, 1'b1, 1'b1, 7'h05, 31'h1234, 8'd2};
    tv[9]  = '{8'h0a, 32'h8000_0055, 1'b1, 1'b1, 1'b0, 7'h06, 31'h11,   8'd2};
    tv[10] = '{8'h0a, 32'h8000_0055, 1'b1, 1'b1, 1'b0, 7'h07, 31'h22,   8'd2};
    tv[11] = '{8'h0a, 32'h8000_0055, 1'b1, 1'b1, 1'b0, 7'h08, 31'h33,   8'd2};
    tv[12] = '{8'h0a, 32'h8000_0055, 1'b1, 1'b0, 1'b0, 7'h00, 31'h0,    8'd2};

    // Reset with send_data[31]=1 held, then walk the table.
    do_reset(8'h05, 32'h8000_1234);
    for (int i = 0; i < 13; i++) begin
      pio_send_addr = tv[i].a; pio_send_data = tv[i].d; noc_tx_ready = tv[i].rdy;
      tick();
      chk($sformatf("tv%0d_valid", i), {31'd0, noc_tx_valid}, {31'd0, tv[i].e_valid});
      chk($sformatf("tv%0d_full", i),  {31'd0, tx_full}, {31'd0, tv[i].e_full});
      chk($sformatf("tv%0d_drop", i),  {24'd0, tx_drop_cnt}, {24'd0, tv[i].e_drop});
      if (tv[i].e_valid) begin
        chk($sformatf("tv%0d_addr", i), {25'd0, noc_tx_addr}, {25'd0, tv[i].e_addr});
        chk($sformatf("tv%0d_data", i), {1'b0, noc_tx_data}, {1'b0, tv[i].e_data});
      end
    end

    // Full TX FIFO plus a toggle and a pop in the same cycle: push accepted.
    noc_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pio_send_addr = 8'h10 + 8'(i);
      pio_send_data = {~pio_send_data[31], 31'h0A0 + 31'(i)};
      tick();
    end
    chk("fill_full", {31'd0, tx_full}, 32'd1);
    pio_send_addr = 8'h14; pio_send_data = {~pio_send_data[31], 31'h0A4}; noc_tx_ready = 1'b1;
    tick();
    chk("simul_full", {31'd0, tx_full}, 32'd1);
    chk("simul_drop", {24'd0, tx_drop_cnt}, 32'd2);
    chk("simul_head", {25'd0, noc_tx_addr}, 32'h11);
    repeat (4) tick();
    chk("simul_drained", {31'd0, noc_tx_valid}, 32'd0);

    // Three back-to-back RX packets, presented in order after each ack.
    ack_bit = 1'b0;
    do_reset({ack_bit, 7'h00}, 32'd0);
    tick();                                   // priming edge
    for (int i = 1; i <= 3; i++) begin
      rx_pkt(1'b1, 7'(i), 31'(i * 256));
      tick();
      if (i == 2) begin
        chk("rx_first_addr", {24'd0, pio_recv_addr}, 32'd1);
        chk("rx_first_tog",  {31'd0, pio_recv_data[31]}, 32'd1);
      end
    end
    rx_pkt(1'b0, 7'd0, 31'd0);
    repeat (3) tick();
    chk("rx_hold_addr", {24'd0, pio_recv_addr}, 32'd1);
    for (int i = 2; i <= 3; i++) begin
      ack_bit = ~ack_bit; pio_send_addr = {ack_bit, 7'h00};
      tick();
      chk($sformatf("rx_ack%0d_wait", i), {24'd0, pio_recv_addr}, 32'(i - 1));
      tick();
      chk($sformatf("rx_ack%0d_addr", i), {24'd0, pio_recv_addr}, 32'(i));
      chk($sformatf("rx_ack%0d_tog", i),  {31'd0, pio_recv_data[31]}, {31'd0, i[0] == 1'b1});
      chk($sformatf("rx_ack%0d_data", i), {1'b0, pio_recv_data[30:0]}, 32'(i * 256));
    end

    // RX flood of 7 packets without ack: 1 presented, 4 queued, 2 dropped.
    ack_bit = 1'b0;
    do_reset({ack_bit, 7'h00}, 32'd0);
    tick();
    for (int i = 0; i < 7; i++) begin
      rx_pkt(1'b1, 7'h20 + 7'(i), 31'h500 + 31'(i));
      tick();
    end
    rx_pkt(1'b0, 7'd0, 31'd0);
    tick();
    chk("flood_drop", {24'd0, rx_drop_cnt}, 32'd2);
    chk("flood_addr", {24'd0, pio_recv_addr}, 32'h20);
    for (int i = 1; i <= 5; i++) begin
      ack_bit = ~ack_bit; pio_send_addr = {ack_bit, 7'h00};
      tick(); tick();
      chk($sformatf("flood_pop%0d", i), {24'd0, pio_recv_addr}, (i == 5) ? 32'h24 : 32'h20 + 32'(i));
    end

    // Asynchronous reset while PR is HELD and both FIFOs hold entries.
    ack_bit = 1'b0;
    do_reset({ack_bit, 7'h00}, 32'd0);
    tick();
    pio_send_data = 32'h8000_0777; pio_send_addr = {ack_bit, 7'h33};
    for (int i = 0; i < 3; i++) begin
      rx_pkt(1'b1, 7'h40 + 7'(i), 31'h900 + 31'(i));
      tick();
    end
    rx_pkt(1'b0, 7'd0, 31'd0);
    tick();
    chk("pre_rst_txv", {31'd0, noc_tx_valid}, 32'd1);
    chk("pre_rst_recv", {24'd0, pio_recv_addr}, 32'h40);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) tick();                        // no stale TX or RX words reappear

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0)
        pio_send_data = {~pio_send_data[31], 31'($urandom)};
      if ($urandom_range(0, 3) == 0) pio_send_addr[7] = ~pio_send_addr[7];
      pio_send_addr[6:0] = 7'($urandom);
      noc_tx_ready = ($urandom_range(0, 2) != 0);
      rx_pkt(($urandom_range(0, 1) == 1), 7'($urandom), 31'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
